// File: rtl/risc16_regfile.sv
// RISC16 register file: two registered operand read ports (S, DS), one write port
// with same-cycle bypass, and a per-register pending scoreboard that stalls reads.
module risc16_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] s_addr,
    input  logic [$clog2(DEPTH)-1:0] ds_addr,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] w_addr,
    input  logic [WIDTH-1:0]         w_data,
    input  logic                     claim_en,
    input  logic [$clog2(DEPTH)-1:0] claim_addr,
    output logic [WIDTH-1:0]         S,
    output logic [WIDTH-1:0]         DS,
    output logic                     out_valid,
    output logic                     stall
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [WIDTH-1:0] s_val, ds_val;
    logic             s_blk, ds_blk, accept;
    logic [WIDTH-1:0] s_p1, ds_p1;
    logic             vld_p1;

    // A same-cycle write supplies the newest value, so it is forwarded ahead of the array.
    function automatic logic [WIDTH-1:0] operand(input logic [AW-1:0] a);
        if (a == '0)
            return '0;
        if (we && w_addr == a)
            return w_data;
        return regs[a];
    endfunction

    function automatic logic blocked(input logic [AW-1:0] a);
        return pending[a] && !(we && w_addr == a);
    endfunction

    always_comb begin
        s_val  = operand(s_addr);
        ds_val = operand(ds_addr);
        s_blk  = blocked(s_addr);
        ds_blk = blocked(ds_addr);
        stall  = !rst && rd_en && (s_blk || ds_blk);
        accept = rd_en && !stall;
    end

    // Stage p0 -> p1: operand capture, register write, scoreboard update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pending <= '0;
            s_p1    <= '0;
            ds_p1   <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (we && w_addr != '0)
                regs[w_addr] <= w_data;
            pending[0] <= 1'b0;
            // A claim in the same cycle as the write is a newer producer, so it wins.
            for (int i = 1; i < DEPTH; i++) begin
                if (claim_en && claim_addr == AW'(i))
                    pending[i] <= 1'b1;
                else if (we && w_addr == AW'(i))
                    pending[i] <= 1'b0;
            end
            vld_p1 <= accept;
            if (accept) begin
                s_p1  <= s_val;
                ds_p1 <= ds_val;
            end
        end
    end

    assign S         = s_p1;
    assign DS        = ds_p1;
    assign out_valid = vld_p1;
endmodule

// File: tb/tb_risc16_regfile.sv
// Self-checking bench for risc16_regfile: expected operand pairs are queued when a
// read is driven and compared when out_valid reports them.
module tb_risc16_regfile;
    logic        clk = 1'b0;
    logic        rst, rd_en, we, claim_en;
    logic [2:0]  s_addr, ds_addr, w_addr, claim_addr;
    logic [15:0] w_data;
    logic [15:0] S, DS;
    logic        out_valid, stall;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];
    logic [15:0] last_s = 16'h0;
    logic [15:0] last_d = 16'h0;

    risc16_regfile #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .s_addr(s_addr), .ds_addr(ds_addr),
        .we(we), .w_addr(w_addr), .w_data(w_data), .claim_en(claim_en),
        .claim_addr(claim_addr), .S(S), .DS(DS), .out_valid(out_valid), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; we = 1'b0; claim_en = 1'b0; rst = 1'b0;
        s_addr = 3'd0; ds_addr = 3'd0; w_addr = 3'd0; claim_addr = 3'd0; w_data = 16'h0;
    endtask

    // Run one clock with the inputs already driven; check stall, then the result.
    task automatic cyc(input string tag, input logic exp_stall);
        logic exp_acc;
        logic rst_now;
        logic [31:0] e;
        #1;
        check({tag, ":stall"}, 32'(stall), 32'(exp_stall));
        rst_now = rst;
        exp_acc = rd_en && !exp_stall && !rst_now;
        @(posedge clk);
        #1;
        if (rst_now) begin
            last_s = 16'h0;
            last_d = 16'h0;
        end
        check({tag, ":out_valid"}, 32'(out_valid), 32'(exp_acc));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check({tag, ":unexpected_read"}, 32'(out_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check({tag, ":S"}, 32'(S), 32'(e[31:16]));
                check({tag, ":DS"}, 32'(DS), 32'(e[15:0]));
                last_s = e[31:16];
                last_d = e[15:0];
            end
        end else begin
            check({tag, ":S_hold"}, 32'(S), 32'(last_s));
            check({tag, ":DS_hold"}, 32'(DS), 32'(last_d));
        end
        idle_inputs();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; w_addr = a; w_data = d;
    endtask

    task automatic claim(input logic [2:0] a);
        claim_en = 1'b1; claim_addr = a;
    endtask

    // Drive a read and, if it should be accepted, queue its expected operands.
    task automatic rd(input string tag, input logic [2:0] s, input logic [2:0] ds,
                      input logic [15:0] es, input logic [15:0] eds, input logic exp_stall);
        rd_en = 1'b1; s_addr = s; ds_addr = ds;
        if (!exp_stall)
            exp_q.push_back({es, eds});
        cyc(tag, exp_stall);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset:out_valid", 32'(out_valid), 32'h0);
        check("reset:S", 32'(S), 32'h0);
        check("reset:DS", 32'(DS), 32'h0);

        // Reset clears registers and overrides write/claim/read in the same cycle
        wr(3'd3, 16'h1234);
        cyc("wr_r3", 1'b0);
        rst = 1'b1; rd_en = 1'b1; s_addr = 3'd3;
        wr(3'd3, 16'hFFFF); claim(3'd3);
        cyc("rst_override", 1'b0);
        rd("after_rst", 3'd3, 3'd0, 16'h0000, 16'h0000, 1'b0);

        // Plain write then read on both ports
        wr(3'd5, 16'hBEEF); cyc("wr_r5", 1'b0);
        wr(3'd6, 16'h0F0F); cyc("wr_r6", 1'b0);
        rd("rd_5_6", 3'd5, 3'd6, 16'hBEEF, 16'h0F0F, 1'b0);
        rd("same_addr", 3'd6, 3'd6, 16'h0F0F, 16'h0F0F, 1'b0);

        // Bypass and R0
        wr(3'd2, 16'hA5A5);
        rd("bypass_r2", 3'd2, 3'd0, 16'hA5A5, 16'h0000, 1'b0);
        wr(3'd0, 16'hFFFF);
        rd("r0_bypass", 3'd0, 3'd2, 16'h0000, 16'hA5A5, 1'b0);
        rd("r0_read", 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0);

        // Scoreboard stall on S, released by a same-cycle write
        claim(3'd4);
        rd("rd5_claim4", 3'd5, 3'd0, 16'hBEEF, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++)
            rd("stall_r4", 3'd4, 3'd0, 16'h0, 16'h0, 1'b1);
        wr(3'd4, 16'h0042);
        rd("release_r4", 3'd4, 3'd0, 16'h0042, 16'h0000, 1'b0);

        // Stall through the DS port
        claim(3'd6); cyc("claim_r6", 1'b0);
        rd("stall_ds6", 3'd5, 3'd6, 16'h0, 16'h0, 1'b1);
        wr(3'd6, 16'h7777);
        rd("release_ds6", 3'd5, 3'd6, 16'hBEEF, 16'h7777, 1'b0);

        // Claim and write to the same register: the claim wins
        claim(3'd7); wr(3'd7, 16'h1111);
        cyc("claim_wr_r7", 1'b0);
        rd("stall_r7", 3'd7, 3'd0, 16'h0, 16'h0, 1'b1);
        rd("stall_r7b", 3'd7, 3'd0, 16'h0, 16'h0, 1'b1);
        wr(3'd7, 16'h2222);
        rd("release_r7", 3'd7, 3'd0, 16'h2222, 16'h0000, 1'b0);
        rd("reread_r7", 3'd7, 3'd4, 16'h2222, 16'h0042, 1'b0);

        // Reset in the middle of a stall drops the request and clears pending
        claim(3'd1); cyc("claim_r1", 1'b0);
        rd("stall_r1", 3'd1, 3'd0, 16'h0, 16'h0, 1'b1);
        rst = 1'b1; rd_en = 1'b1; s_addr = 3'd1;
        cyc("rst_midstall", 1'b0);
        rd("after_rst_r1", 3'd1, 3'd0, 16'h0000, 16'h0000, 1'b0);
        rd("after_rst_r5", 3'd5, 3'd7, 16'h0000, 16'h0000, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/risc16_regfile.md
# risc16_regfile

Eight-entry, 16-bit register file for the RISC16 datapath that produces the source (S) and destination-source (DS) operands consumed by the S/DS operand-select mux directly downstream. It has two registered read ports, one write port with same-cycle write-through bypass, and a per-register pending scoreboard that stalls operand reads until an outstanding result has been written back. R0 is hardwired to zero.

## Interface
Parameters:
- WIDTH, 16, data width of every register and operand port
- DEPTH, 8, number of registers; address width is log2(DEPTH) = 3

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- rd_en  input  1  request operand read this cycle
- s_addr  input  3  register index for the S operand
- ds_addr  input  3  register index for the DS operand
- we  input  1  write enable
- w_addr  input  3  write register index
- w_data  input  16  write data
- claim_en  input  1  mark claim_addr as pending (result outstanding)
- claim_addr  input  3  register to mark pending
- S  output  16  registered S operand
- DS  output  16  registered DS operand
- out_valid  output  1  S/DS updated by an accepted read on the previous edge
- stall  output  1  combinational: read request blocked by a pending operand

## Operation
- Storage: regs[1..7], 16 bits each. R0 reads 0 always. Writes to R0 are ignored.
- Write: on a clock edge with we=1 and w_addr!=0, regs[w_addr] <= w_data.
- Scoreboard: pending[7:1].
  - claim_en=1 with claim_addr!=0 sets pending[claim_addr].
  - we=1 clears pending[w_addr].
  - If claim and write target the same address in one cycle, the claim wins and the bit ends set, because it is a newer producer.
  - pending[0] is constant 0.
- Operand value per port, here S: if we && w_addr==s_addr && s_addr!=0, use w_data (bypass). Else use regs[s_addr]. R0 gives 0. The DS port behaves the same way.
- Operand blocked: pending[addr]=1 and not written this cycle. A same-cycle write clears the block and its data is bypassed.
- stall = rd_en && (S operand blocked || DS operand blocked).
- Accepted read (rd_en && !stall): S and DS load the operand values and out_valid <= 1.
- Otherwise (idle or stalled): S and DS hold and out_valid <= 0.
- The upstream holds addresses and rd_en asserted while stall=1.

## Timing
- Reset (rst=1 at an edge): all regs=0, pending=0, S=0, DS=0, out_valid=0. rst overrides we, claim_en and rd_en in the same cycle. stall is forced to 0 while rst=1.
- Read latency: 1 cycle. Operands for addresses presented at edge N appear on S/DS with out_valid=1 after edge N.
- Write-to-read: 0 extra cycles with bypass. A read in the same cycle as the write returns the new data.
- Claim-to-stall: a claim at edge N makes stall visible from cycle N+1 onward for reads of that register.
- stall is combinational from rd_en, the addresses, pending, we and w_addr. It has no registered delay.
- s_addr==ds_addr is legal, and both outputs get the same value.
- Reset mid-stall drops the request: out_valid=0 and all pending bits are cleared.

## Test plan
- Reset: write R3=0x1234, then assert rst for 1 cycle. A read of s_addr=3, ds_addr=0 then gives S=0x0000, DS=0x0000, out_valid=1 one cycle after rd_en.
- Write/read: write R5=0xBEEF, R6=0x0F0F. The next cycle, rd_en with s=5, ds=6 gives S=0xBEEF, DS=0x0F0F and out_valid=1 after one edge.
- Bypass and R0: in the same cycle, we=1 with w_addr=2, w_data=0xA5A5, plus rd_en with s=2, ds=0. Result is S=0xA5A5, DS=0. Then write R0=0xFFFF and read R0, which returns 0.
- Scoreboard stall: claim R4, then hold rd_en with s=4 for 3 cycles. stall=1 and out_valid=0 each cycle, and S holds its old value. Then we=1 with w_addr=4, w_data=0x0042 in the same cycle as the read. stall drops to 0 and S=0x0042 on the next edge.
- Claim/write collision: in one cycle, claim R7 and write R7=0x1111. Next cycle a read of R7 stalls. A later write R7=0x2222 releases it and the read returns S=0x2222.
- Reset mid-stall: claim R1, stall a read of R1, then assert rst. After rst, out_valid=0 and a read of R1 is accepted without stall and returns 0.
